// File: rtl/ecap5_dproc_pkg.sv
// Shared processor types used by the memory arbiter.
// State and master encodings for the ifm/lsm Wishbone arbiter.
package ecap5_dproc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_IF,
        GRANT_LS
    } mem_arb_state_t;

    typedef enum logic {
        MASTER_IF,
        MASTER_LS
    } mem_arb_master_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-master (ifm, lsm) arbiter for the pipelined Wishbone memory port.
// MEM_ARBITER_ROUND_ROBIN_EN: ties go to the master not granted last.
import ecap5_dproc_pkg::*;

module mem_arbiter (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic [31:0] if_wb_adr_i,
    output logic [31:0] if_wb_dat_o,
    input  logic        if_wb_we_i,
    input  logic [3:0]  if_wb_sel_i,
    input  logic        if_wb_stb_i,
    input  logic        if_wb_cyc_i,
    output logic        if_wb_ack_o,
    output logic        if_wb_stall_o,

    input  logic [31:0] ls_wb_adr_i,
    input  logic [31:0] ls_wb_dat_i,
    output logic [31:0] ls_wb_dat_o,
    input  logic        ls_wb_we_i,
    input  logic [3:0]  ls_wb_sel_i,
    input  logic        ls_wb_stb_i,
    input  logic        ls_wb_cyc_i,
    output logic        ls_wb_ack_o,
    output logic        ls_wb_stall_o,

    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_stall_i
);

    mem_arb_state_t  r_state;
    mem_arb_master_t r_last_grant;
    mem_arb_master_t w_tie_pick;
    mem_arb_state_t  w_tie_state;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    assign w_tie_pick = (r_last_grant == MASTER_LS) ? MASTER_IF : MASTER_LS;
`else
    // Fixed priority: lsm wins regardless of history.
    assign w_tie_pick = (r_last_grant == MASTER_LS) ? MASTER_LS : MASTER_LS;
`endif

    assign w_tie_state = (w_tie_pick == MASTER_IF) ? GRANT_IF : GRANT_LS;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_last_grant <= MASTER_LS;
        end else begin
            unique case (r_state)
                IDLE: begin
                    unique case (1'b1)
                        (if_wb_cyc_i && ls_wb_cyc_i): begin
                            r_state      <= w_tie_state;
                            r_last_grant <= w_tie_pick;
                        end
                        (if_wb_cyc_i && !ls_wb_cyc_i): begin
                            r_state      <= GRANT_IF;
                            r_last_grant <= MASTER_IF;
                        end
                        (!if_wb_cyc_i && ls_wb_cyc_i): begin
                            r_state      <= GRANT_LS;
                            r_last_grant <= MASTER_LS;
                        end
                        default: r_state <= IDLE;
                    endcase
                end
                GRANT_IF: begin
                    if (!if_wb_cyc_i) begin
                        if (ls_wb_cyc_i) begin
                            r_state      <= GRANT_LS;
                            r_last_grant <= MASTER_LS;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                GRANT_LS: begin
                    if (!ls_wb_cyc_i) begin
                        if (if_wb_cyc_i) begin
                            r_state      <= GRANT_IF;
                            r_last_grant <= MASTER_IF;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Read data is broadcast; each master qualifies it with its own ack.
    assign if_wb_dat_o = wb_dat_i;
    assign ls_wb_dat_o = wb_dat_i;

    always_comb begin
        wb_adr_o      = 32'h0;
        wb_dat_o      = 32'h0;
        wb_we_o       = 1'b0;
        wb_sel_o      = 4'h0;
        wb_stb_o      = 1'b0;
        wb_cyc_o      = 1'b0;
        if_wb_ack_o   = 1'b0;
        if_wb_stall_o = 1'b1;
        ls_wb_ack_o   = 1'b0;
        ls_wb_stall_o = 1'b1;
        unique case (r_state)
            GRANT_IF: begin
                wb_adr_o      = if_wb_adr_i;
                wb_we_o       = if_wb_we_i;
                wb_sel_o      = if_wb_sel_i;
                wb_stb_o      = if_wb_stb_i;
                wb_cyc_o      = if_wb_cyc_i;
                if_wb_ack_o   = wb_ack_i;
                if_wb_stall_o = wb_stall_i;
            end
            GRANT_LS: begin
                wb_adr_o      = ls_wb_adr_i;
                wb_dat_o      = ls_wb_dat_i;
                wb_we_o       = ls_wb_we_i;
                wb_sel_o      = ls_wb_sel_i;
                wb_stb_o      = ls_wb_stb_i;
                wb_cyc_o      = ls_wb_cyc_i;
                ls_wb_ack_o   = wb_ack_i;
                ls_wb_stall_o = wb_stall_i;
            end
            default: ;
        endcase
    end

endmodule
